// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_pkg
//  Description : Shared definitions for the program loader.
//                Covers the instruction width, the pad word, the default
//                memory address width and the loader FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    localparam int          INSTR_W       = 32;
    // Pad pattern for unfilled lanes. All-zero encodes sll $0,$0,0, which is a NOP.
    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
    localparam int          IM_AW_DEFAULT = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_byte_packer
//  Description : Packs accepted bytes big-endian into 32-bit words. The first
//                byte lands in the MSB lane. A word is emitted on its 4th byte,
//                or early when the byte carries "last". Unfilled low lanes
//                then keep the NOP pad.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader_byte_packer
    import prog_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               byte_valid_i,
    input  logic [7:0]         byte_i,
    input  logic               byte_last_i,
    output logic [INSTR_W-1:0] word_o,
    output logic               word_valid_o
);

    logic [1:0]         idx_q, idx_d;
    logic [INSTR_W-1:0] acc_q, acc_d;
    logic [INSTR_W-1:0] merged;

    // Insert the incoming byte into its lane. Lanes not yet filled still hold the pad.
    always_comb begin
        merged = acc_q;
        case (idx_q)
            2'd0:    merged[31:24] = byte_i;
            2'd1:    merged[23:16] = byte_i;
            2'd2:    merged[15:8]  = byte_i;
            default: merged[7:0]   = byte_i;
        endcase
    end

    assign word_o       = merged;
    assign word_valid_o = byte_valid_i & ((idx_q == 2'd3) | byte_last_i);

    // Next-state logic. A word emission or a clear restarts assembly from the pad word.
    always_comb begin
        idx_d = idx_q;
        acc_d = acc_q;
        if (clear_i) begin
            idx_d = 2'd0;
            acc_d = NOP_WORD;
        end else if (byte_valid_i) begin
            if (word_valid_o) begin
                idx_d = 2'd0;
                acc_d = NOP_WORD;
            end else begin
                idx_d = idx_q + 2'd1;
                acc_d = merged;
            end
        end
    end

    // Byte index and assembly register.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= 2'd0;
            acc_q <= NOP_WORD;
        end else begin
            idx_q <= idx_d;
            acc_q <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Boot-time program loader for the MIPS core. It streams bytes
//                into instruction memory, holding the core during the load.
//                It then pulses a PC clear and releases the core.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int IM_AW         = IM_AW_DEFAULT,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               im_we,
    output logic [IM_AW-1:0]   im_addr,
    output logic [INSTR_W-1:0] im_wdata,
    output logic               cpu_hold,
    output logic               pc_clear,
    output logic               done,
    output logic               err_overflow,
    output logic [IM_AW:0]     word_count
);

    localparam logic [IM_AW:0] DEPTH = {1'b1, {IM_AW{1'b0}}};

    state_t               state_q, state_d;
    logic                 enter_load;
    logic                 accept;
    logic [INSTR_W-1:0]   pk_word;
    logic                 pk_word_valid;

    logic                 im_we_q;
    logic [IM_AW-1:0]     im_addr_q;
    logic [INSTR_W-1:0]   im_wdata_q;
    logic [IM_AW:0]       word_count_q;
    logic                 err_q;

    // Stream is always ready while loading; writes never back-pressure it.
    assign in_ready = (state_q == ST_LOAD);
    assign accept   = in_valid & in_ready;

    prog_loader_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (enter_load),
        .byte_valid_i (accept),
        .byte_i       (in_data),
        .byte_last_i  (in_last),
        .word_o       (pk_word),
        .word_valid_o (pk_word_valid)
    );

    // FSM next state. start is honoured only from IDLE or DONE.
    always_comb begin
        state_d    = state_q;
        enter_load = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    enter_load = 1'b1;
                end
            end
            ST_LOAD:    if (accept && in_last) state_d = ST_FLUSH;
            ST_FLUSH:   state_d = ST_RELEASE;
            ST_RELEASE: state_d = ST_DONE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Write issue, address/count tracking and sticky overflow.
    // A write that is due when memory is full is dropped, and the error is flagged instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            im_we_q      <= 1'b0;
            im_addr_q    <= '0;
            im_wdata_q   <= '0;
            word_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            im_we_q <= 1'b0;
            if (enter_load) begin
                im_addr_q    <= '0;
                word_count_q <= '0;
                err_q        <= 1'b0;
            end else if (pk_word_valid) begin
                if (word_count_q == DEPTH) begin
                    err_q <= 1'b1;
                end else begin
                    im_we_q      <= 1'b1;
                    im_addr_q    <= word_count_q[IM_AW-1:0];
                    im_wdata_q   <= pk_word;
                    word_count_q <= word_count_q + 1'b1;
                end
            end
        end
    end

    assign im_we        = im_we_q;
    assign im_addr      = im_addr_q;
    assign im_wdata     = im_wdata_q;
    assign word_count   = word_count_q;
    assign err_overflow = err_q;

    // Core sequencing is decoded from the registered state. IDLE keeps the reset hold policy.
    assign pc_clear = (state_q == ST_RELEASE);
    assign done     = (state_q == ST_DONE);
    assign cpu_hold = (state_q == ST_IDLE) ? HOLD_AT_RESET : (state_q != ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader. Two instances share one
//                byte stream: a 32-word instance that holds the core at reset,
//                and a 4-word instance that runs the core from reset. The
//                expected words come from a byte-list reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_prog_loader;

    localparam int AW_A  = 5;
    localparam int AW_B  = 2;
    localparam int DEP_A = 32;
    localparam int DEP_B = 4;

    logic clk = 1'b0;
    logic rst, start, in_valid, in_last;
    logic [7:0] in_data;

    logic            a_in_ready, a_im_we, a_cpu_hold, a_pc_clear, a_done, a_err;
    logic [AW_A-1:0] a_im_addr;
    logic [31:0]     a_im_wdata;
    logic [AW_A:0]   a_word_count;
    logic            b_in_ready, b_im_we, b_cpu_hold, b_pc_clear, b_done, b_err;
    logic [AW_B-1:0] b_im_addr;
    logic [31:0]     b_im_wdata;
    logic [AW_B:0]   b_word_count;

    always #5 clk = ~clk;

    prog_loader #(.IM_AW(AW_A), .HOLD_AT_RESET(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .im_we(a_im_we), .im_addr(a_im_addr),
        .im_wdata(a_im_wdata), .cpu_hold(a_cpu_hold), .pc_clear(a_pc_clear), .done(a_done),
        .err_overflow(a_err), .word_count(a_word_count)
    );

    prog_loader #(.IM_AW(AW_B), .HOLD_AT_RESET(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .im_we(b_im_we), .im_addr(b_im_addr),
        .im_wdata(b_im_wdata), .cpu_hold(b_cpu_hold), .pc_clear(b_pc_clear), .done(b_done),
        .err_overflow(b_err), .word_count(b_word_count)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [31:0] mem_a [DEP_A];
    logic [31:0] mem_b [DEP_B];
    logic [37:0] log_a [$];
    logic [37:0] log_b [$];
    logic [7:0]  prog  [$];
    logic [31:0] exp_w [$];

    // Instruction-memory models and write logs, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_im_we) begin
            mem_a[a_im_addr] = a_im_wdata;
            log_a.push_back({6'(a_im_addr), a_im_wdata});
        end
        if (b_im_we) begin
            mem_b[b_im_addr] = b_im_wdata;
            log_b.push_back({6'(b_im_addr), b_im_wdata});
        end
    end

    // Reference: bytes in groups of four, first byte in the MSB, a short tail padded with zeros.
    function automatic void build_words();
        exp_w.delete();
        for (int w = 0; w * 4 < prog.size(); w++) begin
            logic [31:0] x;
            x = 32'h0;
            for (int k = 0; k < 4; k++)
                if (w * 4 + k < prog.size()) x[31 - 8 * k -: 8] = prog[w * 4 + k];
            exp_w.push_back(x);
        end
    endfunction

    function automatic void rand_prog(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
    endfunction

    // Full load of prog[]: start, stream (optional gaps / stray start pulses), and check the
    // release sequence, flags, counts and every memory write of both instances.
    task automatic run_load(input bit gaps, input bit start_mid, input bit start_rel);
        int n;
        int ea, eb;
        bit ova, ovb;
        n = prog.size();
        build_words();
        ova = (exp_w.size() > DEP_A);
        ovb = (exp_w.size() > DEP_B);
        ea  = ova ? DEP_A : exp_w.size();
        eb  = ovb ? DEP_B : exp_w.size();
        log_a.delete();
        log_b.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cmp_cnt++; if (a_cpu_hold !== 1'b1) begin err_cnt++; $display("FAIL load_entry_hold_a: got %b want 1", a_cpu_hold); end
        cmp_cnt++; if (b_cpu_hold !== 1'b1) begin err_cnt++; $display("FAIL load_entry_hold_b: got %b want 1", b_cpu_hold); end
        cmp_cnt++; if ({a_done, a_err, b_done, b_err} !== 4'b0000) begin err_cnt++; $display("FAIL load_entry_flags: got %b want 0000", {a_done, a_err, b_done, b_err}); end
        cmp_cnt++; if (a_word_count !== '0 || b_word_count !== '0) begin err_cnt++; $display("FAIL load_entry_count: got %0d/%0d want 0/0", a_word_count, b_word_count); end
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) begin
                    in_valid = 1'b0;
                    cmp_cnt++; if ({a_in_ready, b_in_ready} !== 2'b11) begin err_cnt++; $display("FAIL ready_in_gap: got %b want 11", {a_in_ready, b_in_ready}); end
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = prog[i];
            in_last  = (i == n - 1);
            start    = start_mid && (i == n / 2);
            cmp_cnt++; if ({a_in_ready, b_in_ready} !== 2'b11) begin err_cnt++; $display("FAIL ready_in_load: byte %0d got %b want 11", i, {a_in_ready, b_in_ready}); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        in_data  = 8'($urandom);
        // One cycle after the last byte: the final write is on the bus.
        cmp_cnt++; if (a_im_we !== (exp_w.size() <= DEP_A)) begin err_cnt++; $display("FAIL final_we_a: got %b want %b", a_im_we, exp_w.size() <= DEP_A); end
        cmp_cnt++; if (b_im_we !== (exp_w.size() <= DEP_B)) begin err_cnt++; $display("FAIL final_we_b: got %b want %b", b_im_we, exp_w.size() <= DEP_B); end
        cmp_cnt++; if (a_word_count !== (AW_A + 1)'(ea)) begin err_cnt++; $display("FAIL flush_count_a: got %0d want %0d", a_word_count, ea); end
        cmp_cnt++; if ({a_in_ready, a_pc_clear} !== 2'b00) begin err_cnt++; $display("FAIL flush_ready_pc: got %b want 00", {a_in_ready, a_pc_clear}); end
        @(negedge clk);
        cmp_cnt++; if ({a_pc_clear, a_cpu_hold, b_pc_clear, b_cpu_hold} !== 4'b1111) begin err_cnt++; $display("FAIL release_pc_hold: got %b want 1111", {a_pc_clear, a_cpu_hold, b_pc_clear, b_cpu_hold}); end
        cmp_cnt++; if (a_done !== 1'b0) begin err_cnt++; $display("FAIL release_done: got %b want 0", a_done); end
        start = start_rel;
        @(negedge clk);
        start = 1'b0;
        cmp_cnt++; if ({a_pc_clear, a_cpu_hold, b_pc_clear, b_cpu_hold} !== 4'b0000) begin err_cnt++; $display("FAIL done_pc_hold: got %b want 0000", {a_pc_clear, a_cpu_hold, b_pc_clear, b_cpu_hold}); end
        cmp_cnt++; if ({a_done, b_done} !== 2'b11) begin err_cnt++; $display("FAIL done_level: got %b want 11", {a_done, b_done}); end
        cmp_cnt++; if ({a_err, b_err} !== {ova, ovb}) begin err_cnt++; $display("FAIL overflow_flag: got %b want %b", {a_err, b_err}, {ova, ovb}); end
        cmp_cnt++; if (a_word_count !== (AW_A + 1)'(ea)) begin err_cnt++; $display("FAIL word_count_a: got %0d want %0d", a_word_count, ea); end
        cmp_cnt++; if (b_word_count !== (AW_B + 1)'(eb)) begin err_cnt++; $display("FAIL word_count_b: got %0d want %0d", b_word_count, eb); end
        @(negedge clk);
        cmp_cnt++; if ({a_done, a_cpu_hold, a_pc_clear} !== 3'b100) begin err_cnt++; $display("FAIL done_stays: got %b want 100", {a_done, a_cpu_hold, a_pc_clear}); end
        cmp_cnt++; if (log_a.size() != ea) begin err_cnt++; $display("FAIL write_count_a: got %0d want %0d", log_a.size(), ea); end
        for (int w = 0; w < ea && w < log_a.size(); w++) begin
            cmp_cnt++; if (log_a[w] !== {6'(w), exp_w[w]}) begin err_cnt++; $display("FAIL write_a[%0d]: got addr %0d data %h want addr %0d data %h", w, log_a[w][37:32], log_a[w][31:0], w, exp_w[w]); end
        end
        cmp_cnt++; if (log_b.size() != eb) begin err_cnt++; $display("FAIL write_count_b: got %0d want %0d", log_b.size(), eb); end
        for (int w = 0; w < eb && w < log_b.size(); w++) begin
            cmp_cnt++; if (log_b[w] !== {6'(w), exp_w[w]}) begin err_cnt++; $display("FAIL write_b[%0d]: got addr %0d data %h want addr %0d data %h", w, log_b[w][37:32], log_b[w][31:0], w, exp_w[w]); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        cmp_cnt++; if ({a_in_ready, a_im_we, a_pc_clear, a_done, a_err} !== 5'b0) begin err_cnt++; $display("FAIL reset_ctrl_a: got %b want 00000", {a_in_ready, a_im_we, a_pc_clear, a_done, a_err}); end
        cmp_cnt++; if ({b_in_ready, b_im_we, b_pc_clear, b_done, b_err} !== 5'b0) begin err_cnt++; $display("FAIL reset_ctrl_b: got %b want 00000", {b_in_ready, b_im_we, b_pc_clear, b_done, b_err}); end
        cmp_cnt++; if (a_im_addr !== '0 || a_im_wdata !== 32'h0) begin err_cnt++; $display("FAIL reset_bus_a: got %0d/%h want 0/0", a_im_addr, a_im_wdata); end
        cmp_cnt++; if (a_word_count !== '0) begin err_cnt++; $display("FAIL reset_count_a: got %0d want 0", a_word_count); end
        cmp_cnt++; if (a_cpu_hold !== 1'b1) begin err_cnt++; $display("FAIL reset_hold_a: got %b want 1", a_cpu_hold); end
        cmp_cnt++; if (b_cpu_hold !== 1'b0) begin err_cnt++; $display("FAIL reset_hold_b: got %b want 0", b_cpu_hold); end
        rst = 1'b0;
        @(negedge clk);
        cmp_cnt++; if ({a_cpu_hold, b_cpu_hold, a_in_ready} !== 3'b100) begin err_cnt++; $display("FAIL idle_after_reset: got %b want 100", {a_cpu_hold, b_cpu_hold, a_in_ready}); end
    endtask

    task automatic test_full_words();
        prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h21, 8'h09, 8'h00, 8'h07};
        run_load(1'b0, 1'b0, 1'b0);
        cmp_cnt++; if (mem_a[0] !== 32'h20080005 || mem_a[1] !== 32'h21090007) begin err_cnt++; $display("FAIL full_words_mem: got %h %h want 20080005 21090007", mem_a[0], mem_a[1]); end
    endtask

    task automatic test_partial_word();
        prog = '{8'h01, 8'h2A, 8'h50, 8'h20, 8'h8C, 8'h08};
        run_load(1'b0, 1'b0, 1'b0);
        cmp_cnt++; if (mem_a[0] !== 32'h012A5020 || mem_a[1] !== 32'h8C080000) begin err_cnt++; $display("FAIL partial_mem: got %h %h want 012A5020 8C080000", mem_a[0], mem_a[1]); end
        rand_prog(5);
        run_load(1'b0, 1'b0, 1'b0);
        rand_prog(1);
        run_load(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        rand_prog(20);
        run_load(1'b0, 1'b0, 1'b0);
        rand_prog(DEP_A * 4 + 2);
        run_load(1'b1, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cmp_cnt++; if ({a_err, b_err, a_done, b_done} !== 4'b0000) begin err_cnt++; $display("FAIL overflow_clear: got %b want 0000", {a_err, b_err, a_done, b_done}); end
    endtask

    task automatic test_reset_midload();
        logic [31:0] w1a, w1b;
        // A restart pulse here lands in LOAD and is ignored by run_load's own start.
        rand_prog(12);
        run_load(1'b0, 1'b0, 1'b0);
        log_a.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        cmp_cnt++; if ({a_in_ready, a_im_we, a_pc_clear, a_done, a_err, a_cpu_hold, b_cpu_hold} !== 7'b0000010) begin err_cnt++; $display("FAIL midload_reset_ctrl: got %b want 0000010", {a_in_ready, a_im_we, a_pc_clear, a_done, a_err, a_cpu_hold, b_cpu_hold}); end
        cmp_cnt++; if (a_word_count !== '0 || a_im_addr !== '0 || a_im_wdata !== 32'h0) begin err_cnt++; $display("FAIL midload_reset_bus: got %0d/%0d/%h want 0/0/0", a_word_count, a_im_addr, a_im_wdata); end
        rst = 1'b0;
        cmp_cnt++; if (log_a.size() != 2) begin err_cnt++; $display("FAIL midload_writes: got %0d want 2", log_a.size()); end
        w1a = mem_a[1];
        w1b = mem_b[1];
        @(negedge clk);
        rand_prog(4);
        run_load(1'b0, 1'b0, 1'b0);
        cmp_cnt++; if (mem_a[1] !== w1a || mem_b[1] !== w1b) begin err_cnt++; $display("FAIL midload_keep: got %h/%h want %h/%h", mem_a[1], mem_b[1], w1a, w1b); end
    endtask

    task automatic test_gaps();
        logic [31:0] img [4];
        rand_prog(16);
        run_load(1'b0, 1'b0, 1'b0);
        for (int w = 0; w < 4; w++) begin
            img[w] = mem_a[w];
            mem_a[w] = 32'hDEAD_BEEF;
        end
        run_load(1'b1, 1'b0, 1'b0);
        for (int w = 0; w < 4; w++) begin
            cmp_cnt++; if (mem_a[w] !== img[w]) begin err_cnt++; $display("FAIL gap_image[%0d]: got %h want %h", w, mem_a[w], img[w]); end
        end
    endtask

    task automatic test_start_ignored();
        rand_prog(13);
        run_load(1'b0, 1'b1, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cmp_cnt++; if ({a_cpu_hold, b_cpu_hold, a_done, b_done} !== 4'b1100) begin err_cnt++; $display("FAIL restart_flags: got %b want 1100", {a_cpu_hold, b_cpu_hold, a_done, b_done}); end
        cmp_cnt++; if (a_word_count !== '0 || b_word_count !== '0) begin err_cnt++; $display("FAIL restart_count: got %0d/%0d want 0/0", a_word_count, b_word_count); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            rand_prog($urandom_range(1, 40));
            run_load(1'b1, 1'(t % 2), 1'b0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_full_words();
        test_partial_word();
        test_overflow();
        test_reset_midload();
        test_gaps();
        test_start_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
